// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the CPU cache-port protocol: word-addressed scratchpad
// that answers each read/write with a single resp pulse after LATENCY cycles.
module cpu_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        read,
  input  logic        write,
  input  logic [3:0]  wmask,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic        resp,
  output logic [31:0] rdata,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          is_rd_q, is_rd_d;
  logic          is_wr_q, is_wr_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [3:0]    wmask_q, wmask_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;

  logic          req_live;
  logic          enter_resp;
  logic          commit;
  logic          eff_rd, eff_wr;
  logic [AW-1:0] eff_idx;
  logic [3:0]    eff_mask;
  logic [31:0]   eff_wdata;
  logic [31:0]   mem_word;
  logic          addr_unused;

  assign addr_unused = ^{address[31:AW+2], address[1:0]};

  // With LATENCY=1 the commit edge is the acceptance edge, so the live inputs
  // must be used there; otherwise the values latched at acceptance apply.
  always_comb begin
    req_live = read | write;
    if (state_q == S_IDLE) begin
      eff_rd    = read;
      eff_wr    = write;
      eff_idx   = address[AW+1:2];
      eff_mask  = wmask;
      eff_wdata = wdata;
    end else begin
      eff_rd    = is_rd_q;
      eff_wr    = is_wr_q;
      eff_idx   = idx_q;
      eff_mask  = wmask_q;
      eff_wdata = wdata_q;
    end
    enter_resp = 1'b0;
    if (state_q == S_IDLE && req_live && LATENCY == 1) enter_resp = 1'b1;
    if (state_q == S_WAIT && req_live && cnt_q == 4'd1) enter_resp = 1'b1;
    commit  = enter_resp & eff_wr;
    rdata_d = (enter_resp & eff_rd) ? mem_word : rdata_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    is_rd_d = is_rd_q;
    is_wr_d = is_wr_q;
    idx_d   = idx_q;
    wmask_d = wmask_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_live) begin
          is_rd_d = read;
          is_wr_d = write;
          idx_d   = address[AW+1:2];
          wmask_d = wmask;
          wdata_d = wdata;
          cnt_d   = LAT_M1;
          state_d = (LATENCY > 1) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        if (!req_live) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd1) begin
          state_d = S_RESP;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      is_rd_q <= 1'b0;
      is_wr_q <= 1'b0;
      idx_q   <= '0;
      wmask_q <= 4'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      is_rd_q <= is_rd_d;
      is_wr_q <= is_wr_d;
      idx_q   <= idx_d;
      wmask_q <= wmask_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    resp  = (state_q == S_RESP);
    busy  = (state_q != S_IDLE);
    rdata = rdata_q;
  end

  // One byte lane per array so each wmask bit gates its own storage.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH_WORDS];
      always_ff @(posedge clk) begin
        if (reset_n && commit && eff_mask[gi]) lane_mem[eff_idx] <= eff_wdata[8*gi +: 8];
      end
      assign mem_word[8*gi +: 8] = lane_mem[eff_idx];
    end
  endgenerate

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Self-checking bench for cpu_mem_responder: directed scenarios plus random traffic
// against a word-array reference model; covers LATENCY=3 and LATENCY=1 instances.
module tb_cpu_mem_responder;

  logic        clk;
  logic        reset_n;
  logic        sel;
  logic        read, write;
  logic [3:0]  wmask;
  logic [31:0] address, wdata;
  logic        read0, write0, read1, write1;
  logic        resp0, resp1, busy0, busy1;
  logic [31:0] rdata0, rdata1;
  logic        resp_s, busy_s;
  logic [31:0] rdata_s;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] ref_mem [0:1][0:255];
  logic [31:0] ref_rdata [0:1];

  assign read0  = read & ~sel;
  assign write0 = write & ~sel;
  assign read1  = read & sel;
  assign write1 = write & sel;
  assign resp_s  = sel ? resp1 : resp0;
  assign busy_s  = sel ? busy1 : busy0;
  assign rdata_s = sel ? rdata1 : rdata0;

  cpu_mem_responder #(.DEPTH_WORDS(256), .LATENCY(3)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .read(read0), .write(write0), .wmask(wmask),
    .address(address), .wdata(wdata), .resp(resp0), .rdata(rdata0), .busy(busy0)
  );

  cpu_mem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .read(read1), .write(write1), .wmask(wmask),
    .address(address), .wdata(wdata), .resp(resp1), .rdata(rdata1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] m);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = m[i] ? d[8*i +: 8] : old[8*i +: 8];
    return r;
  endfunction

  // Issues one request on the selected instance, checks latency, busy and rdata,
  // then releases the request and checks the return to idle.
  task automatic txn(input logic rd, input logic wr, input logic [31:0] addr,
                     input logic [3:0] m, input logic [31:0] d);
    int lat, n, dsel;
    logic [7:0]  idx;
    logic [31:0] old;
    lat  = sel ? 1 : 3;
    dsel = sel ? 1 : 0;
    idx  = addr[9:2];
    old  = ref_mem[dsel][idx];
    read = rd; write = wr; address = addr; wmask = m; wdata = d;
    n = 0;
    for (int k = 0; k < lat + 3; k++) begin
      @(posedge clk); #1;
      n++;
      if (resp_s) break;
      address = $urandom; wdata = $urandom; wmask = 4'($urandom);
    end
    check("latency", 32'(n), 32'(lat));
    check("busy_in_resp", {31'd0, busy_s}, 32'd1);
    if (rd) ref_rdata[dsel] = old;
    if (wr) ref_mem[dsel][idx] = merge(old, d, m);
    check("rdata", rdata_s, ref_rdata[dsel]);
    $display("txn dut%0d rd=%0b wr=%0b addr=%h mask=%h wdata=%h -> lat=%0d rdata=%h",
             dsel, rd, wr, addr, m, d, n, rdata_s);
    read = 1'b0; write = 1'b0;
    @(posedge clk); #1;
    check("resp_after", {31'd0, resp_s}, 32'd0);
    check("busy_after", {31'd0, busy_s}, 32'd0);
  endtask

  initial begin
    int n;
    logic [31:0] a;
    reset_n = 1'b0; sel = 1'b0; read = 1'b0; write = 1'b0;
    wmask = 4'h0; address = 32'd0; wdata = 32'd0;
    ref_rdata[0] = 32'd0; ref_rdata[1] = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_resp0", {31'd0, resp0}, 32'd0);
    check("rst_busy0", {31'd0, busy0}, 32'd0);
    check("rst_rdata0", rdata0, 32'd0);
    check("rst_resp1", {31'd0, resp1}, 32'd0);
    check("rst_busy1", {31'd0, busy1}, 32'd0);
    check("rst_rdata1", rdata1, 32'd0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;

    // Full write then read-back, then masked overwrite.
    txn(1'b0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    txn(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
    check("full_write_read", rdata_s, 32'hDEADBEEF);
    txn(1'b0, 1'b1, 32'h10, 4'b0101, 32'h11223344);
    txn(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
    check("masked_read", rdata_s, 32'hDE22BE44);

    // Address wrap: 0x400 aliases word 0.
    txn(1'b0, 1'b1, 32'h400, 4'hF, 32'hCAFEF00D);
    txn(1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
    check("wrap_read", rdata_s, 32'hCAFEF00D);
    txn(1'b0, 1'b1, 32'h4, 4'h0, 32'hFFFFFFFF);

    for (int i = 0; i < 16; i++) txn(1'b0, 1'b1, 32'(i * 4), 4'hF, $urandom);

    // Held read across three addresses: first after LATENCY, then every LATENCY+1.
    read = 1'b1; address = 32'h0;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      for (int k = 0; k < 8; k++) begin
        @(posedge clk); #1;
        n++;
        if (resp0) break;
      end
      check("held_interval", 32'(n), (i == 0) ? 32'd3 : 32'd4);
      ref_rdata[0] = ref_mem[0][i];
      check("held_rdata", rdata0, ref_rdata[0]);
      $display("held read addr=%h interval=%0d rdata=%h", 32'(i * 4), n, rdata0);
      address = 32'((i + 1) * 4);
    end
    read = 1'b0;
    @(posedge clk); #1;
    check("held_busy_end", {31'd0, busy0}, 32'd0);

    // Abort a read, then abort a write; neither responds nor commits.
    read = 1'b1; address = 32'h0;
    @(posedge clk); #1;
    read = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("abort_rd_noresp", {31'd0, resp0}, 32'd0);
    end
    check("abort_rd_busy", {31'd0, busy0}, 32'd0);
    txn(1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
    write = 1'b1; address = 32'h4; wmask = 4'hF; wdata = ~ref_mem[0][1];
    @(posedge clk); #1;
    write = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check("abort_wr_noresp", {31'd0, resp0}, 32'd0);
    end
    txn(1'b1, 1'b0, 32'h4, 4'h0, 32'h0);
    $display("abort sequence done rdata=%h", rdata0);

    // Reset in the middle of a write's wait period.
    write = 1'b1; address = 32'h20; wmask = 4'hF; wdata = ~ref_mem[0][8];
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check("midrst_resp", {31'd0, resp0}, 32'd0);
    check("midrst_busy", {31'd0, busy0}, 32'd0);
    check("midrst_rdata", rdata0, 32'd0);
    ref_rdata[0] = 32'd0; ref_rdata[1] = 32'd0;
    write = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    txn(1'b1, 1'b0, 32'h20, 4'h0, 32'h0);
    $display("reset mid-wait: word 0x20 reads %h", rdata0);

    // Random traffic over the initialised words, upper address bits randomised.
    for (int i = 0; i < 40; i++) begin
      int op;
      op = $urandom_range(0, 2);
      a  = ($urandom & 32'hFFFF_FC03) | (32'($urandom_range(0, 15)) << 2);
      txn(op != 1, op != 0, a, 4'($urandom_range(0, 15)), $urandom);
    end

    // LATENCY=1 instance: immediate resp, wrap, masked write.
    sel = 1'b1;
    txn(1'b0, 1'b1, 32'h400, 4'hF, 32'h12345678);
    txn(1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
    check("l1_wrap_read", rdata_s, 32'h12345678);
    txn(1'b0, 1'b1, 32'h0, 4'b1010, 32'hAABBCCDD);
    txn(1'b1, 1'b1, 32'h0, 4'b0001, 32'h000000EE);
    check("l1_both_rdata", rdata_s, 32'hAA34CC78);
    txn(1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
    check("l1_final", rdata_s, 32'hAA34CCEE);
    sel = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
